md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- HI/LO multiply-divide unit in the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from E using forwarded rs/rt operands.
- Runs a fixed-latency operation, exposing busy for the stall controller and HI/LO values for the E-stage mfhi/mflo result mux and M/W forwarding.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu (and madd-family when enabled); legal range 1..31
DIV_CYCLES, 10, busy duration in cycles for div/divu; legal range 1..31

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  E-stage instruction is a HI/LO op; qualifies md_op
md_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu
rs_data  input  32  forwarded rs operand (E-stage ALU A input after forwarding mux)
rt_data  input  32  forwarded rt operand (E-stage ALU B input after forwarding mux)
busy  output  1  operation in flight; high for exactly N cycles after accepted mult/div
hi  output  32  architectural HI register
lo  output  32  architectural LO register

Behaviour:
- Reset: busy=0, hi=0, lo=0, internal counter=0, pending result cleared. Reset mid-operation aborts the op and discards its result.
- States: IDLE, RUN.
- IDLE: start with op 1-4 (or 7-10 when enabled) latches rs_data, rt_data and op at the edge. Enters RUN with counter=N (N = MULT_CYCLES or DIV_CYCLES). busy=1 from the next cycle.
- RUN: counter decrements each cycle. In the cycle counter==1, the next edge writes hi/lo, clears busy and returns to IDLE. busy is therefore high for exactly N cycles, and new hi/lo are visible in the first cycle busy=0.
- The result is computed from the latched operands only. Operand changes during RUN have no effect.
- mult: signed 32x32 to 64; hi=upper word, lo=lower word. multu: unsigned equivalent.
- div: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend. divu: unsigned.
- Divide by zero: hi/lo keep their previous values. busy still runs the full DIV_CYCLES.
- mthi/mtlo in IDLE: hi (or lo) <= rs_data at the next edge. No busy, no RUN entry.
- start while busy=1 is ignored entirely, whatever the op. The stall controller must keep HI/LO instructions in D while (busy | start).
- start with md_op 0 or an undefined code is a no-op.
- hi/lo change only at the completion edge, on mthi/mtlo, or on reset. No partial results are visible during RUN.
- Back-to-back: start in the first cycle after busy falls is accepted normally.

Optional Feature:
- MD_MADD_EN defined: ops 7-10 are legal and use MULT_CYCLES latency.
  - madd: {hi,lo} += signed product.
  - maddu: {hi,lo} += unsigned product.
  - msub: {hi,lo} -= signed product.
  - msubu: {hi,lo} -= unsigned product.
  - 64-bit wrap-around, no saturation. The accumulator base is the {hi,lo} value at completion time.
- MD_MADD_EN undefined: codes 7-10 are treated as undefined (no-op, busy stays 0).

Test Plan:
- reset; start mult, rs=0xFFFFFFFD (-3), rt=5 -> busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- start multu, rs=0xFFFFFFFF, rt=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- start div, rs=0xFFFFFFF9 (-7), rt=2 -> busy for 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu rs=7, rt=2 -> lo=3, hi=1.
- mthi rs=0x12345678, then mtlo rs=0x9ABCDEF0 -> hi/lo updated one edge later, busy never asserts. Then divu by rt=0 -> 10 busy cycles, hi/lo unchanged.
- start mult, and on busy cycle 3 pulse start mthi rs=0xDEAD and change rs/rt -> mthi ignored, mult result matches the original operands. Assert reset on cycle 2 of a second mult -> busy=0, hi=lo=0 next cycle.
- MD_MADD_EN: set hi=0, lo=0xFFFFFFFF via mtlo, madd rs=1, rt=1 -> hi=1, lo=0. msubu rs=1, rt=1 -> hi=0, lo=0xFFFFFFFF.

Source files
------------

// File: rtl/md_unit.sv
// ============================================================================
// Module   : md_unit
// Purpose  : MIPS E-stage HI/LO multiply/divide unit with fixed-latency busy.
//            Define MD_MADD_EN to enable madd/maddu/msub/msubu (codes 7-10).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d;

  logic        long_op, div_op;
  logic [63:0] prod_s, prod_u;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;
  logic [63:0] res;
  logic        res_we;

  // Sign-extended 64-bit multiply gives the signed product modulo 2^64.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign quot_s = $signed(a_q) / $signed(b_q);
  assign rem_s  = $signed(a_q) % $signed(b_q);
  assign quot_u = a_q / b_q;
  assign rem_u  = a_q % b_q;

  always_comb begin
    div_op  = (md_op == OP_DIV) || (md_op == OP_DIVU);
    long_op = div_op || (md_op == OP_MULT) || (md_op == OP_MULTU);
`ifdef MD_MADD_EN
    long_op = long_op || (md_op == OP_MADD) || (md_op == OP_MADDU) ||
              (md_op == OP_MSUB) || (md_op == OP_MSUBU);
`endif
  end

  always_comb begin
    res    = {hi_q, lo_q};
    res_we = 1'b0;
    case (op_q)
      OP_MULT:  begin res = prod_s; res_we = 1'b1; end
      OP_MULTU: begin res = prod_u; res_we = 1'b1; end
      OP_DIV:   begin res = {rem_s, quot_s}; res_we = (b_q != 32'd0); end
      OP_DIVU:  begin res = {rem_u, quot_u}; res_we = (b_q != 32'd0); end
`ifdef MD_MADD_EN
      OP_MADD:  begin res = {hi_q, lo_q} + prod_s; res_we = 1'b1; end
      OP_MADDU: begin res = {hi_q, lo_q} + prod_u; res_we = 1'b1; end
      OP_MSUB:  begin res = {hi_q, lo_q} - prod_s; res_we = 1'b1; end
      OP_MSUBU: begin res = {hi_q, lo_q} - prod_u; res_we = 1'b1; end
`endif
      default:  begin res = {hi_q, lo_q}; res_we = 1'b0; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (long_op) begin
            state_d = RUN;
            op_d    = md_op;
            a_d     = rs_data;
            b_d     = rt_data;
            cnt_d   = div_op ? DIV_N : MULT_N;
          end else if (md_op == OP_MTHI) begin
            hi_d = rs_data;
          end else if (md_op == OP_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = IDLE;
          if (res_we) begin
            hi_d = res[63:32];
            lo_d = res[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module   : tb_md_unit
// Purpose  : Directed self-checking bench for md_unit (MULT=5, DIV=10).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    md_op   = op;
    rs_data = a;
    rt_data = b;
    tick();
    start   = 1'b0;
    md_op   = 4'd0;
  endtask

  // Busy must stay high for n cycles while HI/LO hold their old values.
  task automatic run_busy(input int n, input string tag, input logic [31:0] hi_old,
                          input logic [31:0] lo_old);
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_hi_hold"}, hi, hi_old);
      check({tag, "_lo_hold"}, lo, lo_old);
      tick();
    end
    check({tag, "_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 4'd0; rs_data = 32'd0; rt_data = 32'd0;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    issue(4'd1, 32'hFFFFFFFD, 32'd5);
    run_busy(5, "mult", 32'd0, 32'd0);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFF1);

    // Issued in the first non-busy cycle: back-to-back acceptance.
    issue(4'd2, 32'hFFFFFFFF, 32'd2);
    run_busy(5, "multu", 32'hFFFFFFFF, 32'hFFFFFFF1);
    check("multu_hi", hi, 32'h00000001);
    check("multu_lo", lo, 32'hFFFFFFFE);

    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    run_busy(10, "div", 32'h00000001, 32'hFFFFFFFE);
    check("div_hi", hi, 32'hFFFFFFFF);
    check("div_lo", lo, 32'hFFFFFFFD);

    issue(4'd4, 32'd7, 32'd2);
    run_busy(10, "divu", 32'hFFFFFFFF, 32'hFFFFFFFD);
    check("divu_hi", hi, 32'd1);
    check("divu_lo", lo, 32'd3);

    issue(4'd5, 32'h12345678, 32'd0);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_lo", lo, 32'd3);
    issue(4'd6, 32'h9ABCDEF0, 32'd0);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mtlo_hi", hi, 32'h12345678);
    check("mtlo_lo", lo, 32'h9ABCDEF0);

    issue(4'd4, 32'd99, 32'd0);
    run_busy(10, "divz", 32'h12345678, 32'h9ABCDEF0);
    check("divz_hi", hi, 32'h12345678);
    check("divz_lo", lo, 32'h9ABCDEF0);

    // Undefined / no-op codes.
    issue(4'd0, 32'h11111111, 32'd1);
    check("op0_busy", {31'd0, busy}, 32'd0);
    issue(4'd11, 32'h22222222, 32'd1);
    check("op11_busy", {31'd0, busy}, 32'd0);
    check("undef_hi", hi, 32'h12345678);
    check("undef_lo", lo, 32'h9ABCDEF0);

    // start during busy is ignored; operand changes have no effect.
    issue(4'd1, 32'h00010000, 32'h00010000);
    check("ign_busy1", {31'd0, busy}, 32'd1);
    tick();
    check("ign_busy2", {31'd0, busy}, 32'd1);
    tick();
    start = 1'b1; md_op = 4'd5; rs_data = 32'h0000DEAD; rt_data = 32'd7;
    check("ign_busy3", {31'd0, busy}, 32'd1);
    tick();
    start = 1'b0; md_op = 4'd0;
    check("ign_hi_hold", hi, 32'h12345678);
    check("ign_busy4", {31'd0, busy}, 32'd1);
    tick();
    check("ign_busy5", {31'd0, busy}, 32'd1);
    tick();
    check("ign_done", {31'd0, busy}, 32'd0);
    check("ign_hi", hi, 32'h00000001);
    check("ign_lo", lo, 32'h00000000);

    // Reset in busy cycle 2 aborts and discards the result.
    issue(4'd1, 32'd3, 32'd3);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("abort_busy_late", {31'd0, busy}, 32'd0);
    check("abort_lo_late", lo, 32'd0);

`ifdef MD_MADD_EN
    issue(4'd6, 32'hFFFFFFFF, 32'd0);
    issue(4'd7, 32'd1, 32'd1);
    run_busy(5, "madd", 32'd0, 32'hFFFFFFFF);
    check("madd_hi", hi, 32'd1);
    check("madd_lo", lo, 32'd0);
    issue(4'd10, 32'd1, 32'd1);
    run_busy(5, "msubu", 32'd1, 32'd0);
    check("msubu_hi", hi, 32'd0);
    check("msubu_lo", lo, 32'hFFFFFFFF);
`else
    issue(4'd7, 32'd1, 32'd1);
    check("madd_off_busy", {31'd0, busy}, 32'd0);
    tick();
    check("madd_off_hi", hi, 32'd0);
    check("madd_off_lo", lo, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
